// File: rtl/ram_ctrl.sv
// ============================================================================
//  Module   : ram_ctrl
//  Purpose  : RAS/CAS sequencer for one parity-protected DRAM bank with
//             interleaved RAS-only refresh and odd-parity generation/check.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ram_ctrl #(
    parameter int REFRESH_INTERVAL = 64,
    parameter int PRECHARGE_CYC    = 1,
    parameter int REFRESH_RAS_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        par_err,
    output logic        par_sticky,
    input  logic        par_clr,
    output logic [7:0]  ma,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic [7:0]  md_out,
    output logic        mdp_out,
    output logic        md_oe,
    input  logic [7:0]  md_in,
    input  logic        mdp_in,
    output logic        ref_ovf
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_ROW  = 3'd1;
    localparam logic [2:0] c_ST_COL  = 3'd2;
    localparam logic [2:0] c_ST_HOLD = 3'd3;
    localparam logic [2:0] c_ST_PRE  = 3'd4;
    localparam logic [2:0] c_ST_RROW = 3'd5;

    localparam int c_CNT_MAX = (PRECHARGE_CYC > REFRESH_RAS_CYC) ? PRECHARGE_CYC : REFRESH_RAS_CYC;
    localparam int c_CW      = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);
    localparam int c_TW      = $clog2(REFRESH_INTERVAL);

    logic [2:0]      state_q, state_d;
    logic [c_CW-1:0] cnt_q, cnt_d;
    logic [15:0]     addr_q, addr_d;
    logic            req_we_q, req_we_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      ref_row_q, ref_row_d;
    logic [c_TW-1:0] timer_q, timer_d;
    logic            pend_q, pend_d;
    logic            ref_clr;
    logic            tick;

    logic            ack_q, ack_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            par_err_q, par_err_d;
    logic            sticky_q, sticky_d;
    logic            ovf_q, ovf_d;
    logic            ras_n_q, ras_n_d;
    logic            cas_n_q, cas_n_d;
    logic            we_n_q, we_n_d;
    logic [7:0]      ma_q, ma_d;
    logic [7:0]      md_out_q, md_out_d;
    logic            mdp_out_q, mdp_out_d;
    logic            md_oe_q, md_oe_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        req_we_d  = req_we_q;
        wdata_d   = wdata_q;
        ref_row_d = ref_row_q;
        ref_clr   = 1'b0;
        ack_d     = 1'b0;
        par_err_d = 1'b0;
        rdata_d   = rdata_q;
        case (state_q)
            c_ST_IDLE: begin
                if (pend_q) begin
                    state_d = c_ST_RROW;
                    cnt_d   = '0;
                end else if (req) begin
                    addr_d   = req_addr;
                    req_we_d = req_we;
                    wdata_d  = req_wdata;
                    state_d  = c_ST_ROW;
                end
            end
            c_ST_ROW:  state_d = c_ST_COL;
            c_ST_COL:  state_d = c_ST_HOLD;
            c_ST_HOLD: begin
                state_d = c_ST_PRE;
                cnt_d   = '0;
                ack_d   = 1'b1;
                if (!req_we_q) begin
                    rdata_d   = md_in;
                    par_err_d = ~(^{mdp_in, md_in});
                end
            end
            c_ST_PRE: begin
                if (cnt_q == c_CW'(PRECHARGE_CYC - 1)) begin
                    state_d = c_ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_ST_RROW: begin
                if (cnt_q == c_CW'(REFRESH_RAS_CYC - 1)) begin
                    state_d   = c_ST_PRE;
                    cnt_d     = '0;
                    ref_row_d = ref_row_q + 8'd1;
                    ref_clr   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    // Strobes and bus drive are decoded from the next state so every pin is a flop.
    always_comb begin
        ras_n_d   = 1'b1;
        cas_n_d   = 1'b1;
        we_n_d    = 1'b1;
        md_oe_d   = 1'b0;
        ma_d      = ma_q;
        md_out_d  = md_out_q;
        mdp_out_d = mdp_out_q;
        case (state_d)
            c_ST_ROW: begin
                ras_n_d = 1'b0;
                ma_d    = addr_d[15:8];
            end
            c_ST_COL, c_ST_HOLD: begin
                ras_n_d = 1'b0;
                cas_n_d = 1'b0;
                ma_d    = addr_q[7:0];
                if (req_we_q) begin
                    we_n_d    = 1'b0;
                    md_oe_d   = 1'b1;
                    md_out_d  = wdata_q;
                    mdp_out_d = ~(^wdata_q);
                end
            end
            c_ST_RROW: begin
                ras_n_d = 1'b0;
                ma_d    = ref_row_q;
            end
            default: ;
        endcase
    end

    // A tick that lands while the previous refresh is still owed is dropped;
    // one that coincides with the refresh completing re-arms the request.
    always_comb begin
        tick    = (timer_q == c_TW'(REFRESH_INTERVAL - 1));
        timer_d = tick ? '0 : timer_q + 1'b1;
        ovf_d   = tick && pend_q && !ref_clr;
        if (tick) begin
            pend_d = 1'b1;
        end else if (ref_clr) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
        sticky_d = par_err_q | (sticky_q & ~par_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            req_we_q  <= 1'b0;
            wdata_q   <= '0;
            ref_row_q <= '0;
            timer_q   <= '0;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            par_err_q <= 1'b0;
            sticky_q  <= 1'b0;
            ovf_q     <= 1'b0;
            ras_n_q   <= 1'b1;
            cas_n_q   <= 1'b1;
            we_n_q    <= 1'b1;
            ma_q      <= '0;
            md_out_q  <= '0;
            mdp_out_q <= 1'b0;
            md_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            req_we_q  <= req_we_d;
            wdata_q   <= wdata_d;
            ref_row_q <= ref_row_d;
            timer_q   <= timer_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            par_err_q <= par_err_d;
            sticky_q  <= sticky_d;
            ovf_q     <= ovf_d;
            ras_n_q   <= ras_n_d;
            cas_n_q   <= cas_n_d;
            we_n_q    <= we_n_d;
            ma_q      <= ma_d;
            md_out_q  <= md_out_d;
            mdp_out_q <= mdp_out_d;
            md_oe_q   <= md_oe_d;
        end
    end

    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign par_err    = par_err_q;
    assign par_sticky = sticky_q;
    assign ref_ovf    = ovf_q;
    assign ras_n      = ras_n_q;
    assign cas_n      = cas_n_q;
    assign we_n       = we_n_q;
    assign ma         = ma_q;
    assign md_out     = md_out_q;
    assign mdp_out    = mdp_out_q;
    assign md_oe      = md_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_ctrl.sv
// ============================================================================
//  Module   : tb_ram_ctrl
//  Purpose  : Randomized scoreboard bench for ram_ctrl with a DRAM bank model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        par_clr = 1'b0;
    logic        ack, par_err, par_sticky, ras_n, cas_n, we_n, mdp_out, md_oe, ref_ovf;
    logic [7:0]  rdata, ma, md_out, md_in;
    logic        mdp_in;

    always #5 clk = ~clk;

    ram_ctrl #(
        .REFRESH_INTERVAL(8),
        .PRECHARGE_CYC   (1),
        .REFRESH_RAS_CYC (2)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .par_err(par_err),
        .par_sticky(par_sticky), .par_clr(par_clr), .ma(ma), .ras_n(ras_n),
        .cas_n(cas_n), .we_n(we_n), .md_out(md_out), .mdp_out(mdp_out),
        .md_oe(md_oe), .md_in(md_in), .mdp_in(mdp_in), .ref_ovf(ref_ovf)
    );

    int checks = 0;
    int failures = 0;

    // DRAM bank: row latched on RAS fall, written while RAS/CAS/WE are low.
    logic [8:0] mem [0:65535];
    logic [7:0] bank_row = '0;
    logic       bank_ras_prev = 1'b1;
    logic       bad_par = 1'b0;
    logic [8:0] bank_rd;

    initial for (int i = 0; i < 65536; i++) mem[i] = 9'd0;

    always @(negedge clk) begin
        if (!ras_n && bank_ras_prev) bank_row = ma;
        if (!ras_n && !cas_n && !we_n) mem[{bank_row, ma}] = {mdp_out, md_out};
        bank_ras_prev = ras_n;
    end

    assign bank_rd = mem[{bank_row, ma}];
    assign md_in   = bank_rd[7:0];
    assign mdp_in  = bank_rd[8] ^ bad_par;

    // Reference contents as seen by the requester.
    logic [7:0]  ref_mem   [0:65535];
    logic        ref_valid [0:65535];
    logic [15:0] waddrs[$];
    initial for (int i = 0; i < 65536; i++) begin ref_mem[i] = 8'd0; ref_valid[i] = 1'b0; end

    typedef struct {
        logic       we;
        logic [7:0] data;
        logic       perr;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ack) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL ack_unexpected actual=1 expected=0");
                end else begin
                    e = sbq.pop_front();
                    if (e.we) begin
                        if (par_err !== 1'b0) begin
                            failures++;
                            $display("FAIL write_par_err actual=%0b expected=0", par_err);
                        end
                    end else if (rdata !== e.data || par_err !== e.perr) begin
                        failures++;
                        $display("FAIL read_resp actual=%0h/%0b expected=%0h/%0b",
                                 rdata, par_err, e.data, e.perr);
                    end
                end
            end else if (par_err) begin
                checks++;
                failures++;
                $display("FAIL par_err_without_ack actual=1 expected=0");
            end
        end
    end

    // Refresh monitor: a RAS-low period with CAS never low is a refresh.
    logic       rm_prev = 1'b1;
    logic       rm_cas = 1'b0;
    logic [7:0] rm_ma = '0;
    int         rm_len = 0;
    logic [7:0] exp_row = '0;
    int         ref_cnt = 0;
    int         ovf_cnt = 0;
    int         cas_low_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_row = '0;
            rm_prev = 1'b1;
        end else begin
            if (ref_ovf) ovf_cnt++;
            if (!cas_n) cas_low_cnt++;
            if (!ras_n && rm_prev) begin
                rm_ma = ma; rm_cas = 1'b0; rm_len = 0;
            end
            if (!ras_n) begin
                rm_len++;
                if (!cas_n) rm_cas = 1'b1;
            end
            if (ras_n && !rm_prev && !rm_cas) begin
                checks++;
                if (rm_ma !== exp_row || rm_len != 2) begin
                    failures++;
                    $display("FAIL refresh_row actual=%0h/len%0d expected=%0h/len2",
                             rm_ma, rm_len, exp_row);
                end
                exp_row = exp_row + 8'd1;
                ref_cnt++;
            end
            rm_prev = ras_n;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0; par_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ras_n, cas_n, we_n, ma, rdata, md_out, mdp_out, md_oe, ack, par_err, par_sticky, ref_ovf},
              {3'b111, 30'd0});
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic we, input logic [15:0] addr, input logic [7:0] data);
        exp_t e;
        e.we = we;
        if (we) begin
            ref_mem[addr] = data;
            if (!ref_valid[addr]) waddrs.push_back(addr);
            ref_valid[addr] = 1'b1;
            e.data = data;
            e.perr = 1'b0;
        end else begin
            e.data = ref_mem[addr];
            e.perr = bad_par;
        end
        sbq.push_back(e);
    endtask

    // Issues one access from a negedge and returns at the ack negedge.
    task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] data,
                          output int lat);
        logic scrambled;
        push_exp(we, addr, data);
        req = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
        scrambled = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (!cas_n && !scrambled) begin
                req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
                scrambled = 1'b1;
            end
            if (ack) break;
            if (lat > 40) begin
                check("ack_timeout", 64'(lat), 64'd9);
                void'(sbq.pop_back());
                break;
            end
        end
        req = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int r0, c0;
        logic [15:0] a;
        logic [15:0] xaddr;

        // Directed write then read with exact strobe timing.
        do_reset();
        push_exp(1'b1, 16'h1234, 8'hA5);
        req = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 8'hA5;
        @(negedge clk);
        check("row_phase", {ras_n, cas_n, ma}, {1'b0, 1'b1, 8'h12});
        @(negedge clk);
        check("col_phase", {ras_n, cas_n, we_n, ma, md_oe, md_out, mdp_out},
              {1'b0, 1'b0, 1'b0, 8'h34, 1'b1, 8'hA5, 1'b1});
        @(negedge clk);
        check("hold_no_ack", {ack, cas_n}, {1'b0, 1'b0});
        @(negedge clk);
        check("write_ack_n4", {ack, ras_n, cas_n, md_oe}, {1'b1, 1'b1, 1'b1, 1'b0});
        req = 1'b0;
        access(1'b0, 16'h1234, 8'h00, lat);
        check("read_latency_after_pre", 64'(lat), 64'd5);

        // Collision: request raised just as the first refresh becomes pending.
        do_reset();
        repeat (8) @(negedge clk);
        access(1'b0, 16'h1234, 8'h00, lat);
        check("collision_latency", 64'(lat), 64'd8);

        // Boundary addresses and randomized traffic.
        access(1'b1, 16'h0000, 8'hFF, lat);
        access(1'b1, 16'hFFFF, 8'h00, lat);
        access(1'b0, 16'hFFFF, 8'h00, lat);
        access(1'b0, 16'h0000, 8'h00, lat);
        for (int n = 0; n < 1500; n++) begin
            if (waddrs.size() > 0 && $urandom_range(0, 1) == 1) begin
                a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                if (ref_valid[a]) access(1'b0, a, 8'h00, lat);
                else access(1'b1, a, 8'($urandom), lat);
            end else begin
                access(1'b1, 16'($urandom), 8'($urandom), lat);
            end
            if (n % 100 == 0) check("latency_in_range", 64'(lat >= 4 && lat <= 9), 64'd1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Parity failure, sticky flag and clear priority.
        bad_par = 1'b1;
        access(1'b0, 16'h1234, 8'h00, lat);
        repeat (2) @(negedge clk);
        check("sticky_set", 64'(par_sticky), 64'd1);
        par_clr = 1'b1;
        access(1'b0, 16'h1234, 8'h00, lat);
        @(negedge clk);
        check("sticky_err_wins_clr", 64'(par_sticky), 64'd1);
        @(negedge clk);
        check("sticky_cleared", 64'(par_sticky), 64'd0);
        par_clr = 1'b0;
        bad_par = 1'b0;
        access(1'b0, 16'h1234, 8'h00, lat);
        repeat (2) @(negedge clk);
        check("sticky_stays_clear", 64'(par_sticky), 64'd0);

        // Reset during the column phase of a write.
        xaddr = 16'hBEEF;
        ref_valid[xaddr] = 1'b0;
        req = 1'b1; req_we = 1'b1; req_addr = xaddr; req_wdata = 8'h3C;
        lat = 0;
        while (cas_n && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("reached_col", 64'(cas_n), 64'd0);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("abort_strobes", {ras_n, cas_n, we_n, md_oe, ack}, {1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        access(1'b1, xaddr, 8'hC3, lat);
        check("post_reset_latency", 64'(lat), 64'd4);
        access(1'b0, xaddr, 8'h00, lat);

        // Idle refresh walk across and past all 256 rows.
        r0 = ref_cnt;
        c0 = cas_low_cnt;
        repeat (2200) @(negedge clk);
        check("idle_refresh_count", 64'((ref_cnt - r0) >= 272 && (ref_cnt - r0) <= 276), 64'd1);
        check("idle_cas_quiet", 64'(cas_low_cnt - c0), 64'd0);

        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
        check("no_ref_ovf", 64'(ovf_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
